mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
//   Executes MULT, MULTU, DIV and DIVU over WIDTH cycles, next to the single-cycle ALU.
//   Also services MTHI/MTLO writes. Results are read combinationally from hi/lo (MFHI/MFLO).
//   Controller stalls the pipeline while busy=1.
// PARAMETERS
//   WIDTH  32  operand width; hi/lo are WIDTH bits each; must be >= 4 and even
// PORTS
//   clk          in   1      clock; all state updates on posedge
//   reset        in   1      synchronous, active-high
//   start        in   1      begin operation op on a, b (accepted only when busy=0)
//   op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a            in   WIDTH  multiplicand / dividend
//   b            in   WIDTH  multiplier / divisor
//   wr_hi        in   1      MTHI: hi <= wdata
//   wr_lo        in   1      MTLO: lo <= wdata
//   wdata        in   WIDTH  data for wr_hi / wr_lo
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse: hi/lo hold the new result
//   div_by_zero  out  1      valid with done; 1 = DIV/DIVU had b==0
//   hi           out  WIDTH  HI register (product upper half / remainder)
//   lo           out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//   Reset: state IDLE; hi=lo=0; busy=done=div_by_zero=0; internal counter 0.
//     Reset in any state, including mid-operation, aborts the operation with these values.
//   FSM states: IDLE -> RUN -> FINISH -> IDLE.
//   IDLE: busy=0.
//     start=1 latches op, |a|, |b|, result signs (signed ops), counter=WIDTH-1; goes to RUN.
//   RUN: busy=1. Each cycle does one step, then counter decrements.
//     MUL step: shift-add radix-2. DIV step: restoring, one quotient bit.
//     RUN lasts exactly WIDTH cycles; counter==0 -> FINISH.
//   FINISH: busy=1.
//     Apply sign fix-up (two's complement negate where required).
//     At this edge write hi/lo and go to IDLE.
//     done=1 and div_by_zero (if applicable) are registered outputs.
//     They are high in the cycle after FINISH, when busy=0.
//   Latency: start sampled at edge E0 -> done=1 and new hi/lo visible after edge E0+WIDTH+1.
//     The result is therefore visible WIDTH+1 cycles after start.
//     done is low in all other cycles. div_by_zero falls with done.
//   start while busy=1: ignored, no effect on the running operation.
//   start and wr_hi/wr_lo in the same IDLE cycle: start wins; the writes are dropped.
//   wr_hi/wr_lo while busy=1: dropped; hi/lo change only at FINISH.
//   wr_hi and wr_lo together in IDLE: both hi and lo get wdata.
//   Back-to-back: start may be asserted in the done cycle (busy=0).
//     It is accepted; done still pulses for the previous result.
//   hi/lo hold their value until the next FINISH, wr_hi/wr_lo, or reset.
//   Arithmetic: MULT/MULTU give the full 2*WIDTH product: {hi,lo} = a*b.
//     MULT is signed; MULTU is unsigned.
//   DIV/DIVU: lo = quotient, hi = remainder.
//     Signed DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
//     Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
//   Divide by zero (b==0): operation still takes WIDTH+1 cycles.
//     Result: lo = all ones, hi = a (unmodified dividend); div_by_zero=1 with done.
// TESTING
//   1. MULTU a=FFFFFFFF b=FFFFFFFF -> done exactly 33 cycles after start;
//      hi=FFFFFFFE lo=00000001.
//   2. MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1.
//      Then DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//   3. DIVU a=00000064 b=0 -> div_by_zero=1 with done; lo=FFFFFFFF hi=00000064.
//      Then DIV 80000000/FFFFFFFF -> lo=80000000 hi=0, div_by_zero=0.
//   4. DIVU 100/7 started; 5 cycles later start MULTU 2*3 and wr_hi=1 wdata=AAAA5555.
//      -> both ignored; result lo=0000000E hi=00000002.
//   5. IDLE: wr_lo=1 wdata=12345678 -> lo=12345678 next cycle, hi unchanged.
//      Same cycle start+wr_hi -> write dropped, operation runs.
//   6. reset=1 at cycle 10 of a MULTU -> next cycle busy=0 done=0 hi=lo=0.
//      A new start runs normally with full latency.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO registers.
// Works on operand magnitudes for WIDTH cycles, then applies a sign fix-up and writes HI/LO.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done, r_dbz;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_opa, r_opb, r_hi, r_lo;

  logic               w_signed, w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_rem, w_quo;
  logic [WIDTH:0]     w_mul_sum, w_div_cand, w_div_diff;
  logic [2*WIDTH-1:0] w_step, w_res;

  always_comb begin
    w_signed = ~op[0];
    w_neg_a  = w_signed & a[WIDTH-1];
    w_neg_b  = w_signed & b[WIDTH-1];
    w_abs_a  = w_neg_a ? -a : a;
    w_abs_b  = w_neg_b ? -b : b;
  end

  // r_p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opa} : '0);
    w_div_cand = r_p[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_div_cand - {1'b0, r_opb};
    if (!r_is_div)
      w_step = {w_mul_sum, r_p[WIDTH-1:1]};
    else if (w_div_diff[WIDTH])
      w_step = {w_div_cand[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
    else
      w_step = {w_div_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    w_quo = r_p[WIDTH-1:0];
    w_rem = r_p[2*WIDTH-1:WIDTH];
    if (!r_is_div)
      w_res = r_neg_q ? -r_p : r_p;
    else if (r_dz)
      w_res = {r_opa, {WIDTH{1'b1}}};
    else
      w_res = {(r_neg_r ? -w_rem : w_rem), (r_neg_q ? -w_quo : w_quo)};
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RUN;
      S_RUN:    if (r_cnt == '0) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_p      <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_cnt    <= CW'(WIDTH - 1);
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= op[1] & w_neg_a;
            r_dz     <= op[1] & (b == '0);
            r_p      <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            // DIV keeps the raw dividend for the divide-by-zero result.
            r_opa    <= op[1] ? a : w_abs_a;
            r_opb    <= w_abs_b;
          end else begin
            if (wr_hi) r_hi <= wdata;
            if (wr_lo) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_p   <= w_step;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FINISH: begin
          {r_hi, r_lo} <= w_res;
          r_done       <= 1'b1;
          r_dbz        <= r_is_div & r_dz;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
